// File: rtl/cosim_regwr_arbiter.sv
// Round-robin merge of N register-write commit records into one ordered FIFO stream.
// Optional occupancy/stall statistics are enabled by defining COSIM_REGWR_STALL_STATS_EN.

package cosim_constants_pkg;
    localparam int REG_KEY_TYPE_W = 4;
    localparam int REG_KEY_ID_W   = 60;
    localparam int FREG_W         = 128;
    localparam int XREG_W         = 64;
endpackage

module cosim_regwr_arbiter
    import cosim_constants_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int DEPTH   = 8
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NUM_SRC-1:0]                 src_valid_i,
    output logic [NUM_SRC-1:0]                 src_ready_o,
    input  logic [NUM_SRC*REG_KEY_TYPE_W-1:0]  src_type_i,
    input  logic [NUM_SRC*REG_KEY_ID_W-1:0]    src_id_i,
    input  logic [NUM_SRC*FREG_W-1:0]          src_data_i,
    output logic                               out_valid_o,
    input  logic                               out_ready_i,
    output logic [REG_KEY_TYPE_W-1:0]          out_type_o,
    output logic [REG_KEY_ID_W-1:0]            out_id_o,
    output logic [FREG_W-1:0]                  out_data_o,
    output logic [$clog2(NUM_SRC)-1:0]         out_src_o,
    output logic                               fifo_full_o
`ifdef COSIM_REGWR_STALL_STATS_EN
    ,
    output logic [31:0]                        stall_cnt_o,
    output logic [$clog2(DEPTH):0]             max_occ_o
`endif
);

    localparam int SRC_W = $clog2(NUM_SRC);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [SRC_W-1:0]          src;
        logic [REG_KEY_TYPE_W-1:0] ktype;
        logic [REG_KEY_ID_W-1:0]   id;
        logic [FREG_W-1:0]         data;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             rec_a [NUM_SRC];
    entry_t             push_entry_s;
    entry_t             head_s;

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SRC_W-1:0]   rr_q, rr_d;

    logic [NUM_SRC-1:0] grant_s;
    logic               gnt_found_s;
    logic [SRC_W-1:0]   gnt_idx_s;
    logic [SRC_W-1:0]   cand_s;
    logic               head_valid_s;
    logic               push_s;
    logic               pop_s;
    logic               space_s;

    // Unpack per-source records; x-reg values keep only the low XREG_W bits.
    always_comb begin
        for (int s = 0; s < NUM_SRC; s++) begin
            rec_a[s].src   = SRC_W'(s);
            rec_a[s].ktype = src_type_i[s*REG_KEY_TYPE_W +: REG_KEY_TYPE_W];
            rec_a[s].id    = src_id_i[s*REG_KEY_ID_W +: REG_KEY_ID_W];
            if (src_type_i[s*REG_KEY_TYPE_W +: REG_KEY_TYPE_W] == 4'd0) begin
                rec_a[s].data = {{(FREG_W-XREG_W){1'b0}}, src_data_i[s*FREG_W +: XREG_W]};
            end else begin
                rec_a[s].data = src_data_i[s*FREG_W +: FREG_W];
            end
        end
    end

    // Round-robin search starting at rr_q; a full FIFO admits a push only alongside a pop.
    always_comb begin
        head_valid_s = (cnt_q != {CNT_W{1'b0}});
        pop_s        = head_valid_s && out_ready_i;
        space_s      = (cnt_q != CNT_W'(DEPTH)) || pop_s;
        grant_s      = {NUM_SRC{1'b0}};
        gnt_found_s  = 1'b0;
        gnt_idx_s    = {SRC_W{1'b0}};
        cand_s       = {SRC_W{1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
            cand_s = SRC_W'((int'(rr_q) + i) % NUM_SRC);
            if (!gnt_found_s && space_s && src_valid_i[cand_s]) begin
                gnt_found_s      = 1'b1;
                gnt_idx_s        = cand_s;
                grant_s[cand_s]  = 1'b1;
            end else begin
                gnt_found_s      = gnt_found_s;
            end
        end
        push_s = gnt_found_s;
    end

    assign src_ready_o = grant_s;

    // Next-state for FIFO pointers, occupancy and the round-robin pointer.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cnt_d        = cnt_q;
        rr_d         = rr_q;
        push_entry_s = rec_a[gnt_idx_s];
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (gnt_idx_s == SRC_W'(NUM_SRC - 1)) begin
                rr_d = {SRC_W{1'b0}};
            end else begin
                rr_d = gnt_idx_s + SRC_W'(1);
            end
        end else begin
            rr_d = rr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Control state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            rr_q     <= {SRC_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            rr_q     <= rr_d;
        end
    end

    // FIFO storage; cleared on reset so no stale record survives a mid-run reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int e = 0; e < DEPTH; e++) begin
                mem_q[e] <= '0;
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= push_entry_s;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

    // Head presentation, forced to zero while the FIFO is empty.
    always_comb begin
        head_s      = mem_q[rd_ptr_q];
        out_valid_o = head_valid_s;
        fifo_full_o = (cnt_q == CNT_W'(DEPTH));
        if (head_valid_s) begin
            out_type_o = head_s.ktype;
            out_id_o   = head_s.id;
            out_data_o = head_s.data;
            out_src_o  = head_s.src;
        end else begin
            out_type_o = {REG_KEY_TYPE_W{1'b0}};
            out_id_o   = {REG_KEY_ID_W{1'b0}};
            out_data_o = {FREG_W{1'b0}};
            out_src_o  = {SRC_W{1'b0}};
        end
    end

`ifdef COSIM_REGWR_STALL_STATS_EN
    logic [31:0]      stall_q, stall_d;
    logic [CNT_W-1:0] max_q, max_d;

    // A stall cycle is any cycle with a requesting source left ungranted; saturates.
    always_comb begin
        stall_d = stall_q;
        max_d   = max_q;
        if ((|(src_valid_i & ~grant_s)) && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end else begin
            stall_d = stall_q;
        end
        if (cnt_d > max_q) begin
            max_d = cnt_d;
        end else begin
            max_d = max_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q <= 32'd0;
            max_q   <= {CNT_W{1'b0}};
        end else begin
            stall_q <= stall_d;
            max_q   <= max_d;
        end
    end

    assign stall_cnt_o = stall_q;
    assign max_occ_o   = max_q;
`else
    // Statistics disabled: no extra ports, core behaviour identical.
`endif

endmodule
